// File: rtl/iomem_arbiter.sv
// iomem_arbiter
// Round-robin arbiter sharing one iomem peripheral bus between two requesters.
// m0 is the SoC iomem port, m1 a secondary master (debug/DMA). The grant is
// held for a whole transaction; a watchdog completes transactions the slave
// never acknowledges so an undecoded address cannot hang a master.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_*/m1_*                requester valid/addr/wdata/wstrb in, ready/rdata out
//   s_valid/s_addr/s_wdata/s_wstrb  forwarded request to the shared bus
//   s_ready/s_rdata          shared bus completion and read data
//   grant                    one-hot current owner, 00 = idle
//   timeout                  one-cycle pulse when the watchdog aborts
module iomem_arbiter #(
  parameter int TIMEOUT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_owner;  // 0 = m0 served last, 1 = m1
  logic [TIMEOUT_BITS-1:0] r_wdog;

  logic w_own0;
  logic w_own1;
  logic w_owning;
  logic w_wdog_full;
  logic w_done;
  logic w_expire;

  assign w_own0      = (r_state == OWN0);
  assign w_own1      = (r_state == OWN1);
  assign w_owning    = w_own0 | w_own1;
  assign w_wdog_full = &r_wdog;
  // s_ready wins over an expiring watchdog in the same cycle.
  assign w_expire    = w_owning & ~s_ready & w_wdog_full;
  assign w_done      = w_owning & (s_ready | w_wdog_full);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next   = r_state;
    s_valid  = w_owning;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    grant    = {w_own1, w_own0};
    timeout  = w_expire;

    case (r_state)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_valid && m1_valid) w_next = r_last_owner ? OWN0 : OWN1;
        else if (m0_valid)        w_next = OWN0;
        else if (m1_valid)        w_next = OWN1;
      end
      OWN0: begin
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = w_done;
        // A watchdog abort returns zero rather than whatever is on the bus.
        if (w_done && s_ready) m0_rdata = s_rdata;
        if (w_done)            w_next   = IDLE;
      end
      OWN1: begin
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = w_done;
        if (w_done && s_ready) m1_rdata = s_rdata;
        if (w_done)            w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_wdog       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        // Start at 1 so the watchdog equals the OWN cycle number; all-ones is
        // then reached on cycle 2^TIMEOUT_BITS-1, before it could wrap.
        r_wdog <= (w_next != IDLE) ? {{(TIMEOUT_BITS-1){1'b0}}, 1'b1} : '0;
      end else if (w_done) begin
        r_wdog       <= '0;
        r_last_owner <= w_own1;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

  localparam int TB_TIMEOUT_BITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT_BITS(TB_TIMEOUT_BITS)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout(timeout)
  );

  typedef struct {
    int          master;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        tmo;
    int          cycles;   // OWN cycles up to and including the ready cycle
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          slave_delay = 0;          // -1 = slave never answers
  logic [31:0] slave_rdata = '0;
  logic        log_en = 1'b0;
  logic [1:0]  glog[$];

  // Slave model: answers slave_delay cycles after s_valid rises; drives
  // s_rdata throughout so that timeout zeroing of rdata is visible.
  initial begin
    int cnt;
    cnt = 0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (s_valid) begin
        cnt++;
        s_rdata = slave_rdata;
        s_ready = (slave_delay >= 0 && cnt > slave_delay);
      end else begin
        cnt = 0;
        s_ready = 1'b0;
        s_rdata = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and compares.
  initial begin
    int          own_cnt;
    exp_t        e;
    logic [1:0]  who;
    logic [31:0] rd, ord;
    own_cnt = 0;
    forever begin
      @(negedge clk);
      if (grant != 2'b00) own_cnt++;
      else                own_cnt = 0;
      if (log_en && (glog.size() == 0 ? grant != 2'b00 : grant != glog[$]))
        glog.push_back(grant);
      checks++;
      if (timeout && !(m0_ready || m1_ready)) begin
        errors++;
        $display("FAIL timeout_no_ready: timeout=1 with no ready");
      end
      if (m0_ready || m1_ready) begin
        who = {m1_ready, m0_ready};
        rd  = m1_ready ? m1_rdata : m0_rdata;
        ord = m1_ready ? m0_rdata : m1_rdata;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: ready=%b with nothing expected", who);
        end else begin
          e = sb.pop_front();
          checks++;
          if (who !== (e.master == 1 ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL ready_owner: got %b want m%0d", who, e.master);
          end
          checks++;
          if (grant !== (e.master == 1 ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL grant: got %b want m%0d", grant, e.master);
          end
          checks++;
          if (s_valid !== 1'b1) begin
            errors++; $display("FAIL s_valid_at_ready: got %b want 1", s_valid);
          end
          checks++;
          if (s_addr !== e.addr || s_wdata !== e.wdata || s_wstrb !== e.wstrb) begin
            errors++;
            $display("FAIL fwd: got %h/%h/%h want %h/%h/%h",
                     s_addr, s_wdata, s_wstrb, e.addr, e.wdata, e.wstrb);
          end
          checks++;
          if (rd !== e.rdata) begin
            errors++; $display("FAIL rdata: got %h want %h", rd, e.rdata);
          end
          checks++;
          if (ord !== 32'h0) begin
            errors++; $display("FAIL nonowner_rdata: got %h want 0", ord);
          end
          checks++;
          if (timeout !== e.tmo) begin
            errors++; $display("FAIL timeout: got %b want %b", timeout, e.tmo);
          end
          checks++;
          if (own_cnt != e.cycles) begin
            errors++; $display("FAIL own_cycles: got %0d want %0d", own_cnt, e.cycles);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  function automatic exp_t mk(input int m, input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] s, input logic [31:0] r,
                              input logic t, input int c);
    exp_t e;
    e.master = m; e.addr = a; e.wdata = w; e.wstrb = s;
    e.rdata = r; e.tmo = t; e.cycles = c;
    return e;
  endfunction

  // One requester transaction: raise valid, hold until ready, drop on the
  // edge that samples ready.
  task automatic do_req(input int m, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s);
    logic got;
    @(posedge clk);
    #1;
    if (m == 0) begin m0_valid = 1'b1; m0_addr = a; m0_wdata = w; m0_wstrb = s; end
    else        begin m1_valid = 1'b1; m1_addr = a; m1_wdata = w; m1_wstrb = s; end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ready : m1_ready;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL req_wait: m%0d got no ready within 100 cycles", m);
    end
    @(posedge clk);
    #1;
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, s_valid, timeout, m0_ready, m1_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b s_valid=%b timeout=%b rdy=%b%b want 0",
               grant, s_valid, timeout, m1_ready, m0_ready);
    end
    checks++;
    if (s_addr !== 0 || s_wdata !== 0 || s_wstrb !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
      errors++;
      $display("FAIL reset_data: %h %h %h %h %h want 0", s_addr, s_wdata, s_wstrb,
               m0_rdata, m1_rdata);
    end
    rst = 1'b0;
  endtask

  // Simultaneous requests straight after reset, twice: m0 first, then strict
  // alternation with an IDLE cycle between grants.
  task automatic test_fairness;
    logic [1:0] fexp[8];
    fexp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    slave_delay = 0;
    slave_rdata = 32'h1111_0000;
    sb.push_back(mk(0, 32'h0300_0010, 32'h10, 4'hF, 32'h1111_0000, 0, 1));
    sb.push_back(mk(1, 32'h0300_0020, 32'h20, 4'h3, 32'h1111_0000, 0, 1));
    sb.push_back(mk(0, 32'h0300_0030, 32'h30, 4'hC, 32'h1111_0000, 0, 1));
    sb.push_back(mk(1, 32'h0300_0040, 32'h40, 4'h1, 32'h1111_0000, 0, 1));
    glog.delete();
    log_en = 1'b1;
    fork
      begin
        do_req(0, 32'h0300_0010, 32'h10, 4'hF);
        do_req(0, 32'h0300_0030, 32'h30, 4'hC);
      end
      begin
        do_req(1, 32'h0300_0020, 32'h20, 4'h3);
        do_req(1, 32'h0300_0040, 32'h40, 4'h1);
      end
    join
    repeat (2) @(negedge clk);
    log_en = 1'b0;
    checks++;
    if (glog.size() != 8) begin
      errors++; $display("FAIL grant_seq_len: got %0d want 8", glog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (glog[i] !== fexp[i]) begin
          errors++; $display("FAIL grant_seq[%0d]: got %b want %b", i, glog[i], fexp[i]);
        end
      end
    end
  endtask

  task automatic test_m0_write;
    slave_delay = 1;
    slave_rdata = 32'h5A5A_0001;
    sb.push_back(mk(0, 32'h0300_0000, 32'h1, 4'hF, 32'h5A5A_0001, 0, 2));
    fork
      do_req(0, 32'h0300_0000, 32'h1, 4'hF);
      begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00) begin
          errors++; $display("FAIL arb_latency: s_valid=%b grant=%b want 0/00", s_valid, grant);
        end
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b1 || grant !== 2'b01) begin
          errors++; $display("FAIL own0_entry: s_valid=%b grant=%b want 1/01", s_valid, grant);
        end
      end
    join
  endtask

  task automatic test_m1_read;
    slave_delay = 2;
    slave_rdata = 32'hA5A5_A5A5;
    sb.push_back(mk(1, 32'h0300_0004, 32'h0, 4'h0, 32'hA5A5_A5A5, 0, 3));
    do_req(1, 32'h0300_0004, 32'h0, 4'h0);
  endtask

  task automatic test_timeout;
    slave_delay = -1;
    slave_rdata = 32'hFFFF_FFFF;
    sb.push_back(mk(0, 32'h0400_0000, 32'hCAFE, 4'h0, 32'h0, 1, 15));
    do_req(0, 32'h0400_0000, 32'hCAFE, 4'h0);
    checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: grant=%b s_valid=%b timeout=%b want 00/0/0",
               grant, s_valid, timeout);
    end
  endtask

  task automatic test_timeout_tie;
    slave_delay = 14;
    slave_rdata = 32'hC0DE_0014;
    sb.push_back(mk(1, 32'h0400_0008, 32'hBEEF, 4'h6, 32'hC0DE_0014, 0, 15));
    do_req(1, 32'h0400_0008, 32'hBEEF, 4'h6);
  endtask

  task automatic test_reset_mid;
    slave_delay = -1;
    slave_rdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    m1_valid = 1'b1; m1_addr = 32'h0300_0100; m1_wdata = 32'h9; m1_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_valid !== 1'b1) begin
      errors++; $display("FAIL own1_before_rst: grant=%b s_valid=%b want 10/1", grant, s_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (s_valid !== 1'b0 || grant !== 2'b00 || m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: s_valid=%b grant=%b m1_ready=%b want 0/00/0",
               s_valid, grant, m1_ready);
    end
    m1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    slave_delay = 0;
    slave_rdata = 32'h0000_0042;
    sb.push_back(mk(0, 32'h0300_0200, 32'hA, 4'hF, 32'h42, 0, 1));
    sb.push_back(mk(1, 32'h0300_0300, 32'hB, 4'h0, 32'h42, 0, 1));
    fork
      do_req(0, 32'h0300_0200, 32'hA, 4'hF);
      do_req(1, 32'h0300_0300, 32'hB, 4'h0);
    join
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_m0_write();
    test_m1_read();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected completions never seen", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Shares one iomem peripheral bus (GPIO and future peripherals) between two requesters with round-robin priority.
- Requester m0 is the soc iomem port. Requester m1 is a secondary master, e.g. a debug/DMA engine.
- Holds the grant for a whole transaction.
- A watchdog completes a transaction the slave never acknowledges, so a missing decode cannot hang a master.

Parameters:
- TIMEOUT_BITS, 8: width of the watchdog counter. A transaction is aborted after 2^TIMEOUT_BITS-1 cycles without s_ready.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m0_valid  in  1  requester 0 transaction request
- m0_ready  out  1  requester 0 completion pulse
- m0_addr  in  32  requester 0 address
- m0_wdata  in  32  requester 0 write data
- m0_wstrb  in  4  requester 0 byte strobes; 0 = read
- m0_rdata  out  32  requester 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_* for requester 1
- s_valid  out  1  request to the shared bus
- s_ready  in  1  shared bus completion
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded strobes
- s_rdata  in  32  shared bus read data
- grant  out  2  one-hot current owner; 00 = idle
- timeout  out  1  one-cycle pulse when the watchdog aborts a transaction

Behaviour:
- Reset values (asynchronous on rst high): state IDLE, grant=00, s_valid=0, s_addr/s_wdata/s_wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, timeout=0, last_owner=1 (so m0 wins the first tie), watchdog=0.
- Reset asserted mid-transaction drops s_valid and grant immediately. The partial transaction is abandoned and no ready is issued.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_valid high -> OWN0.
  - Only m1_valid high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Neither -> stay IDLE.
  - Arbitration is registered: request seen at edge N, s_valid high from cycle N+1.
- OWNx:
  - s_valid=1; s_addr/s_wdata/s_wstrb driven combinationally from mx_*.
  - grant[x]=1; watchdog increments each cycle.
  - The other master's valid is ignored; its ready stays 0.
- Completion: s_ready high while in OWNx.
  - mx_ready=1 combinationally in the same cycle; mx_rdata=s_rdata (combinational, valid only while mx_ready).
  - Next edge -> IDLE, last_owner=x, watchdog cleared.
- Timeout: watchdog reaches all-ones with s_ready low.
  - In that cycle mx_ready=1, mx_rdata=32'h00000000, timeout=1, s_valid stays 1.
  - Next edge -> IDLE, s_valid drops.
  - s_ready arriving in the same cycle as the timeout takes precedence: normal completion, timeout=0.
- Requester rule: mx_valid and its addr/data/wstrb are held stable until mx_ready, and valid is dropped on the edge ready is sampled. The arbiter does not re-check mx_valid while owning.
- Latency: minimum 2 cycles request-to-ready (1 arbitration cycle plus 1 for a combinational slave). Minimum 1 IDLE cycle between consecutive transactions.
- Fairness: under continuous requests from both masters, grants strictly alternate.
- Non-owner rdata is 0; non-owner ready is always 0.
- Watchdog width is TIMEOUT_BITS, unsigned, saturation impossible because exit precedes wrap.

Test Plan:
- m0 write: addr 0x03000000, wdata 0x1, wstrb 0xF, slave ready 1 cycle after s_valid -> s_addr=0x03000000, s_wstrb=0xF, m0_ready 1 cycle, grant=01, m1_ready never high.
- m0 and m1 request in the same cycle after reset -> m0 served first, then m1 after one IDLE cycle. Repeat both requests -> m0 then m1 again; grant sequence 01,00,10,00,01,...
- m1 read, slave returns s_rdata=0xA5A5A5A5 on ready -> m1_rdata=0xA5A5A5A5 during m1_ready, m0_rdata=0.
- Slave never responds, TIMEOUT_BITS=4 -> m0_ready and timeout pulse on the 15th OWN0 cycle with m0_rdata=0, then IDLE.
- s_ready and timeout in the same cycle -> normal completion, timeout=0, rdata=s_rdata.
- rst asserted during OWN1 with s_valid=1 -> s_valid, grant and m1_ready go 0 without waiting for a clock edge. After release, a simultaneous request grants m0.
